// File: rtl/wallace_tree_mult_pipe_if.sv
// ---------------------------------------------------------------------------
// wallace_tree_mult_pipe_if
//   Operand/result bundle for the pipelined Wallace-tree multiplier.
//   Signals:
//     A         signed 16-bit multiplicand   (master -> slave)
//     B         signed 16-bit multiplier     (master -> slave)
//     C         signed 32-bit product        (slave  -> master)
//   With WALLACE_VALID_EN defined, two more signals are added:
//     in_valid  operand pair qualifier       (master -> slave)
//     out_valid product qualifier            (slave  -> master)
//   Modports: master drives operands, slave (the multiplier) drives results.
// ---------------------------------------------------------------------------
interface wallace_tree_mult_pipe_if;
    logic signed [15:0] A;
    logic signed [15:0] B;
    logic signed [31:0] C;
`ifdef WALLACE_VALID_EN
    logic               in_valid;
    logic               out_valid;

    modport master (output A, B, in_valid, input  C, out_valid);
    modport slave  (input  A, B, in_valid, output C, out_valid);
`else
    modport master (output A, B, input  C);
    modport slave  (input  A, B, output C);
`endif
endinterface

// File: rtl/wallace_tree_mult_pipe.sv
// ---------------------------------------------------------------------------
// wallace_tree_mult_pipe
//   Pipelined signed 16x16 -> 32-bit multiplier. Baugh-Wooley partial
//   products are reduced by a Wallace tree of 3:2 carry-save adders and
//   resolved by one final carry-propagate add. One pair accepted per clock,
//   result in C six rising edges later (sampled at edge k, visible after k+5).
//
//   Stages: S1 operands | S2 partial products + CSA level 17->12
//           S3 12->8->6 | S4 6->4->3 | S5 3->2 | S6 final add into C
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-low reset, clears every register
//     bus  wallace_tree_mult_pipe_if.slave (A, B in; C out)
//
//   Optional build macro WALLACE_VALID_EN: adds in_valid/out_valid; a valid
//   bit rides a shift register alongside the data and each stage register
//   only loads when the data entering it is valid.
// ---------------------------------------------------------------------------
module wallace_tree_mult_pipe (
    input  logic                   clk,
    input  logic                   rst,
    wallace_tree_mult_pipe_if.slave bus
);
    localparam int N   = 16;
    localparam int W   = 2 * N;
    localparam int LAT = 6;

    typedef logic [W-1:0] vec_t;
    typedef struct packed {
        vec_t s;
        vec_t c;
    } csa_t;

    // Baugh-Wooley correction: +2^N and +2^(2N-1), carries past bit 31 dropped.
    localparam vec_t BW_CORR = 32'h8001_0000;

    // 3:2 compressor over whole vectors; the carry is already weighted
    // one column up, and the carry out of bit 31 is discarded.
    function automatic csa_t csa3(input vec_t x, input vec_t y, input vec_t z);
        csa_t r;
        vec_t maj;
        maj = (x & y) | (x & z) | (y & z);
        r.s = x ^ y ^ z;
        r.c = {maj[W-2:0], 1'b0};
        return r;
    endfunction

    logic [N-1:0]   a_q, a_d, b_q, b_d;
    vec_t           pp      [N+1];
    vec_t           rows2_q [12];
    vec_t           rows2_d [12];
    vec_t           l3      [8];
    vec_t           rows3_q [6];
    vec_t           rows3_d [6];
    vec_t           l4      [4];
    vec_t           rows4_q [3];
    vec_t           rows4_d [3];
    vec_t           rows5_q [2];
    vec_t           rows5_d [2];
    vec_t           c_q, c_d;
    logic [LAT-1:0] stage_en;   // bit n: load enable of stage n+1

`ifdef WALLACE_VALID_EN
    logic [LAT-1:0] v_q, v_d;

    always_comb begin
        v_d      = {v_q[LAT-2:0], bus.in_valid};
        // A stage loads exactly when the data arriving at it is valid.
        stage_en = v_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) v_q <= '0;
        else      v_q <= v_d;
    end

    assign bus.out_valid = v_q[LAT-1];
`else
    assign stage_en = '1;
`endif

    // ---- S1: operand capture --------------------------------------------
    // NOTE: every always_comb output gets a default first (here the held
    // value), so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (stage_en[0]) begin
            a_d = bus.A;
            b_d = bus.B;
        end
    end

    // ---- S2: Baugh-Wooley partial products ------------------------------
    // Row i is A*b[i] shifted by i. Terms pairing exactly one sign bit are
    // inverted: bit 15 of rows 0..14, bits 0..14 of row 15.
    for (genvar i = 0; i < N; i++) begin : g_pp
        localparam logic [N-1:0] INV = (i == N-1) ? 16'h7FFF : 16'h8000;
        assign pp[i] = vec_t'((a_q & {N{b_q[i]}}) ^ INV) << i;
    end
    assign pp[N] = BW_CORR;

    // First CSA level, 17 -> 12 rows.
    always_comb begin
        rows2_d = rows2_q;
        if (stage_en[1]) begin
            {rows2_d[0], rows2_d[1]} = csa3(pp[0],  pp[1],  pp[2]);
            {rows2_d[2], rows2_d[3]} = csa3(pp[3],  pp[4],  pp[5]);
            {rows2_d[4], rows2_d[5]} = csa3(pp[6],  pp[7],  pp[8]);
            {rows2_d[6], rows2_d[7]} = csa3(pp[9],  pp[10], pp[11]);
            {rows2_d[8], rows2_d[9]} = csa3(pp[12], pp[13], pp[14]);
            rows2_d[10] = pp[15];
            rows2_d[11] = pp[16];
        end
    end

    // ---- S3: 12 -> 8 -> 6 -------------------------------------------------
    always_comb begin
        {l3[0], l3[1]} = csa3(rows2_q[0], rows2_q[1],  rows2_q[2]);
        {l3[2], l3[3]} = csa3(rows2_q[3], rows2_q[4],  rows2_q[5]);
        {l3[4], l3[5]} = csa3(rows2_q[6], rows2_q[7],  rows2_q[8]);
        {l3[6], l3[7]} = csa3(rows2_q[9], rows2_q[10], rows2_q[11]);
        rows3_d = rows3_q;
        if (stage_en[2]) begin
            {rows3_d[0], rows3_d[1]} = csa3(l3[0], l3[1], l3[2]);
            {rows3_d[2], rows3_d[3]} = csa3(l3[3], l3[4], l3[5]);
            rows3_d[4] = l3[6];
            rows3_d[5] = l3[7];
        end
    end

    // ---- S4: 6 -> 4 -> 3 --------------------------------------------------
    always_comb begin
        {l4[0], l4[1]} = csa3(rows3_q[0], rows3_q[1], rows3_q[2]);
        {l4[2], l4[3]} = csa3(rows3_q[3], rows3_q[4], rows3_q[5]);
        rows4_d = rows4_q;
        if (stage_en[3]) begin
            {rows4_d[0], rows4_d[1]} = csa3(l4[0], l4[1], l4[2]);
            rows4_d[2] = l4[3];
        end
    end

    // ---- S5: 3 -> 2 -------------------------------------------------------
    always_comb begin
        rows5_d = rows5_q;
        if (stage_en[4]) {rows5_d[0], rows5_d[1]} = csa3(rows4_q[0], rows4_q[1], rows4_q[2]);
    end

    // ---- S6: final carry-propagate add (mod 2^32) -------------------------
    always_comb begin
        c_d = stage_en[5] ? rows5_q[0] + rows5_q[1] : c_q;
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // stage samples the previous-cycle value of the stage before it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the pipeline arrays are small register banks, not RAM,
            // so they are cleared like any other flop; no X leaves reset.
            a_q     <= '0;
            b_q     <= '0;
            rows2_q <= '{default: '0};
            rows3_q <= '{default: '0};
            rows4_q <= '{default: '0};
            rows5_q <= '{default: '0};
            c_q     <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            rows2_q <= rows2_d;
            rows3_q <= rows3_d;
            rows4_q <= rows4_d;
            rows5_q <= rows5_d;
            c_q     <= c_d;
        end
    end

    assign bus.C = c_q;

endmodule

// File: tb/tb_wallace_tree_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_wallace_tree_mult_pipe
//   Scoreboard bench for wallace_tree_mult_pipe. The driver applies one
//   input set per cycle (on the falling edge) and pushes what C must read
//   five edges later, computed with plain integer multiplication. A reset
//   cycle zeroes every in-flight expectation. The monitor pops one entry
//   per rising edge and compares. Build with WALLACE_VALID_EN to also
//   exercise in_valid/out_valid.
// ---------------------------------------------------------------------------
module tb_wallace_tree_mult_pipe;
    logic clk = 1'b1;
    logic rst;

    wallace_tree_mult_pipe_if bus_if ();

    wallace_tree_mult_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        int expv;
        int a;
        int b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_no  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want,
                         input int a, input int b);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s edge %0d: got %0d (0x%h) expected %0d (0x%h) [A=%0d B=%0d]",
                      name, edge_no, $signed(got), got, $signed(want), want, a, b);
    endtask

    // Apply one input set for the next rising edge and record its expectation.
    task automatic drive(input bit r, input int a, input int b, input bit v);
        exp_t e;
        @(negedge clk);
        rst      = r;
        bus_if.A = 16'(a);
        bus_if.B = 16'(b);
`ifdef WALLACE_VALID_EN
        bus_if.in_valid = v;
`endif
        if (!r) begin
            foreach (exp_q[i]) begin
                exp_q[i].vld  = 1'b0;
                exp_q[i].expv = 0;
            end
            e = '{1'b0, 0, a, b};
        end else begin
            e = '{v, int'(shortint'(a)) * int'(shortint'(b)), int'(shortint'(a)), int'(shortint'(b))};
        end
        exp_q.push_back(e);
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Monitor: after each rising edge compare against the entry issued 5 edges ago.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (exp_q.size() > 5) begin
                e = exp_q.pop_front();
`ifdef WALLACE_VALID_EN
                check("out_valid", {31'b0, bus_if.out_valid}, {31'b0, e.vld}, e.a, e.b);
                if (e.vld) check("C_valid", bus_if.C, 32'(e.expv), e.a, e.b);
`else
                check("C", bus_if.C, 32'(e.expv), e.a, e.b);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int dir_a[11] = '{7, -5, -8, 15,   0, -1,    32767, -32768, -32768, 32767, -32768};
    int dir_b[11] = '{3,  4, -6,  0, -25, 32767, 1,     1,      -32768, 32767, 32767};

    initial begin
        rst      = 1'b0;
        bus_if.A = '0;
        bus_if.B = '0;
`ifdef WALLACE_VALID_EN
        bus_if.in_valid = 1'b0;
`endif
        // Registers read 0 from the first reset edge on.
        repeat (5) exp_q.push_back('{1'b0, 0, 0, 0});

        // Reset held two cycles with live-looking operands, then release.
        repeat (2) drive(1'b0, 1234, -99, 1'b1);

        // Directed signed corners and extremes, each held for six cycles.
        for (int i = 0; i < 11; i++)
            repeat (6) drive(1'b1, dir_a[i], dir_b[i], 1'b1);

        // Streaming random pairs with a one-cycle reset in the middle.
        for (int i = 0; i < 1000; i++) begin
`ifdef WALLACE_VALID_EN
            drive(i != 500, rnd16(), rnd16(), $urandom_range(0, 3) != 0);
`else
            drive(i != 500, rnd16(), rnd16(), 1'b1);
`endif
        end

`ifdef WALLACE_VALID_EN
        // Valid pattern 1,0,1,1,0 must reappear on out_valid six cycles later.
        drive(1'b1, rnd16(), rnd16(), 1'b1);
        drive(1'b1, rnd16(), rnd16(), 1'b0);
        drive(1'b1, rnd16(), rnd16(), 1'b1);
        drive(1'b1, rnd16(), rnd16(), 1'b1);
        drive(1'b1, rnd16(), rnd16(), 1'b0);
`endif

        // Flush so every issued entry above reaches the monitor.
        repeat (6) drive(1'b1, 0, 0, 1'b0);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
